// File: rtl/steer_pkg.sv
// Shared types and default thresholds for the steering-enable controller.
package steer_pkg;

  // Controller states; the encoding is visible on state_o when STEER_STATUS_EN is defined.
  typedef enum logic [1:0] {
    INIT     = 2'd0,
    SETTLE   = 2'd1,
    STEER    = 2'd2,
    STEP_OFF = 2'd3
  } steer_st_t;

  // Defaults for a 12-bit load cell and a 50 MHz clock.
  localparam int unsigned DEF_MIN_RIDER  = 32'h200;
  localparam int unsigned DEF_WT_HYST    = 32'h040;
  localparam int unsigned DEF_SETTLE_CYC = 65_000_000;
  localparam int unsigned DEF_GRACE_CYC  = 5_000_000;

  // True in the states where the rider is allowed to steer.
  function automatic logic is_steering(input steer_st_t st);
    return (st == STEER) || (st == STEP_OFF);
  endfunction

endpackage

// File: rtl/steer_ld_cmp.sv
// Registered load-cell compare stage: forms sum/|diff| of the two readings and
// latches the weight and ratio flags on every ld_vld strobe; flags hold otherwise.
module steer_ld_cmp
  import steer_pkg::*;
#(
  parameter int unsigned LD_W      = 12,
  parameter int unsigned MIN_RIDER = DEF_MIN_RIDER,
  parameter int unsigned WT_HYST   = DEF_WT_HYST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  output logic            sum_gt,
  output logic            sum_lt,
  output logic            diff_1_4,
  output logic            diff_15_16
);

  localparam int unsigned SW = LD_W + 1;
  localparam logic [SW-1:0] HI_THR = SW'(MIN_RIDER + WT_HYST);
  localparam logic [SW-1:0] LO_THR = SW'(MIN_RIDER - WT_HYST);

  logic [SW-1:0]   sum;
  logic [LD_W-1:0] diff;
  logic [SW-1:0]   diff_x;
  logic [SW-1:0]   thr_15_16;

  // Combinational sum, absolute difference and the 15/16-of-sum threshold.
  always_comb begin
    sum       = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff      = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    diff_x    = {1'b0, diff};
    thr_15_16 = sum - (sum >> 4);
  end

  // Latch all four flags together on a strobe so they always describe one sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_gt     <= 1'b0;
      sum_lt     <= 1'b0;
      diff_1_4   <= 1'b0;
      diff_15_16 <= 1'b0;
    end else if (ld_vld) begin
      sum_gt     <= (sum > HI_THR);
      sum_lt     <= (sum < LO_THR);
      diff_1_4   <= (diff_x > (sum >> 2));
      diff_15_16 <= (diff_x > thr_15_16);
    end
  end

endmodule

// File: rtl/steer_en_ctrl.sv
// Steering-enable controller for the balance loop: load-cell compare stage plus
// INIT/SETTLE/STEER/STEP_OFF state machine with a saturating settle/grace timer.
// Optional STEER_STATUS_EN adds state_o and a saturating drop_cnt.
module steer_en_ctrl
  import steer_pkg::*;
#(
  parameter int unsigned LD_W       = 12,
  parameter int unsigned MIN_RIDER  = DEF_MIN_RIDER,
  parameter int unsigned WT_HYST    = DEF_WT_HYST,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned GRACE_CYC  = DEF_GRACE_CYC,
  parameter int unsigned TMR_W      = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
`ifdef STEER_STATUS_EN
  output logic [1:0]      state_o,
  output logic [7:0]      drop_cnt,
`endif
  output logic            en_steer,
  output logic            rider_off
);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GRACE_LAST  = TMR_W'(GRACE_CYC - 1);

  logic sum_gt;
  logic sum_lt;
  logic diff_1_4;
  logic diff_15_16;

  steer_st_t        state;
  steer_st_t        next_state;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic [TMR_W-1:0] tmr_inc;

  steer_ld_cmp #(
    .LD_W      (LD_W),
    .MIN_RIDER (MIN_RIDER),
    .WT_HYST   (WT_HYST)
  ) u_ld_cmp (
    .clk        (clk),
    .rst        (rst),
    .lft_ld     (lft_ld),
    .rght_ld    (rght_ld),
    .ld_vld     (ld_vld),
    .sum_gt     (sum_gt),
    .sum_lt     (sum_lt),
    .diff_1_4   (diff_1_4),
    .diff_15_16 (diff_15_16)
  );

  // Next-state and timer action; sum_lt always wins, timer saturates instead of wrapping.
  always_comb begin
    tmr_inc    = (&tmr) ? tmr : tmr + 1'b1;
    next_state = state;
    tmr_nxt    = tmr;
    case (state)
      INIT: begin
        if (sum_gt) begin
          next_state = SETTLE;
          tmr_nxt    = '0;
        end
      end
      SETTLE: begin
        if (sum_lt) begin
          next_state = INIT;
          tmr_nxt    = '0;
        end else if (tmr == SETTLE_LAST) begin
          next_state = STEER;
          tmr_nxt    = '0;
        end else if (diff_1_4) begin
          tmr_nxt = '0;
        end else begin
          tmr_nxt = tmr_inc;
        end
      end
      STEER: begin
        if (sum_lt) begin
          next_state = INIT;
          tmr_nxt    = '0;
        end else if (diff_15_16) begin
          next_state = STEP_OFF;
          tmr_nxt    = '0;
        end
      end
      STEP_OFF: begin
        if (sum_lt) begin
          next_state = INIT;
          tmr_nxt    = '0;
        end else if (!diff_1_4) begin
          next_state = STEER;
        end else if (tmr == GRACE_LAST) begin
          next_state = SETTLE;
          tmr_nxt    = '0;
        end else begin
          tmr_nxt = tmr_inc;
        end
      end
      default: begin
        next_state = INIT;
        tmr_nxt    = '0;
      end
    endcase
  end

  // State, timer and outputs; outputs decode next_state so they move on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      tmr       <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state     <= next_state;
      tmr       <= tmr_nxt;
      en_steer  <= is_steering(next_state);
      rider_off <= (next_state == INIT);
    end
  end

`ifdef STEER_STATUS_EN
  logic dropping;

  // A drop is any exit from a steering state straight back to INIT.
  always_comb begin
    dropping = is_steering(state) && (next_state == INIT);
  end

  // Saturating count of rider drops since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (dropping && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign state_o = state;
`endif

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Bench for steer_en_ctrl: cycle-level reference model of the rider rules plus
// directed scenarios with hand-computed timing. Honors STEER_STATUS_EN.
module tb_steer_en_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        en_steer;
  logic        rider_off;
`ifdef STEER_STATUS_EN
  logic [1:0]  state_o;
  logic [7:0]  drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  steer_en_ctrl #(
    .LD_W       (12),
    .MIN_RIDER  (512),
    .WT_HYST    (64),
    .SETTLE_CYC (16),
    .GRACE_CYC  (4),
    .TMR_W      (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .ld_vld    (ld_vld),
`ifdef STEER_STATUS_EN
    .state_o   (state_o),
    .drop_cnt  (drop_cnt),
`endif
    .en_steer  (en_steer),
    .rider_off (rider_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: rider phases 0=no rider, 1=settling, 2=steering, 3=stepping off.
  int m_phase = 0;
  int m_balanced = 0;   // consecutive balanced cycles counted while settling
  int m_grace = 0;      // cycles spent stepping off
  int m_drops = 0;
  bit m_heavy = 0, m_light = 0, m_tilt = 0, m_off = 0;
  bit m_en = 0, m_ro = 1, m_live = 0;

  always @(posedge clk) begin
    int s, d, nx;
    if (rst) begin
      nx = 0; m_balanced = 0; m_grace = 0; m_drops = 0;
      m_heavy = 0; m_light = 0; m_tilt = 0; m_off = 0;
      m_live = 1;
    end else begin
      nx = m_phase;
      if (m_phase == 0) begin
        if (m_heavy) begin nx = 1; m_balanced = 0; end
      end else if (m_phase == 1) begin
        if (m_light) nx = 0;
        else if (m_balanced == 15) nx = 2;
        else if (m_tilt) m_balanced = 0;
        else m_balanced = m_balanced + 1;
      end else if (m_phase == 2) begin
        if (m_light) begin nx = 0; m_drops++; end
        else if (m_off) begin nx = 3; m_grace = 0; end
      end else begin
        if (m_light) begin nx = 0; m_drops++; end
        else if (!m_tilt) nx = 2;
        else if (m_grace == 3) begin nx = 1; m_balanced = 0; end
        else m_grace = m_grace + 1;
      end
      if (ld_vld) begin
        s = int'(lft_ld) + int'(rght_ld);
        d = (lft_ld > rght_ld) ? int'(lft_ld) - int'(rght_ld) : int'(rght_ld) - int'(lft_ld);
        m_heavy = (s > 576);
        m_light = (s < 448);
        m_tilt  = (d > s / 4);
        m_off   = (d > s - s / 16);
      end
    end
    if (m_drops > 255) m_drops = 255;
    m_phase = nx;
    m_en = (nx >= 2);
    m_ro = (nx == 0);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("model_en_steer", int'(en_steer), int'(m_en));
      chk("model_rider_off", int'(rider_off), int'(m_ro));
`ifdef STEER_STATUS_EN
      chk("model_state", int'(state_o), m_phase);
      chk("model_drop_cnt", int'(drop_cnt), m_drops);
`endif
    end
  end

  // Edges (sampled #1 after) until en_steer equals val; returns max on timeout.
  task automatic wait_en(input logic val, input int max, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (en_steer !== val && n < max);
  endtask

  task automatic drive(input int l, input int r);
    @(negedge clk);
    lft_ld  = 12'(l);
    rght_ld = 12'(r);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; ld_vld = 1'b0; lft_ld = '0; rght_ld = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en_steer", int'(en_steer), 0);
    chk("rst_rider_off", int'(rider_off), 1);

    // 1: empty platform strobed
    @(negedge clk); rst = 1'b0; ld_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_en_steer", int'(en_steer), 0);
    chk("t1_rider_off", int'(rider_off), 1);
`ifdef STEER_STATUS_EN
    chk("t1_state", int'(state_o), 0);
`endif

    // 2: balanced rider, latency from first strobe to en_steer
    drive(400, 400);
    wait_en(1'b1, 40, n);
    chk("t2_rise_edges", n, 18);

    // 3: tilts in SETTLE keep restarting the settle timer
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t3_settle_ro", int'(rider_off), 0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      drive(600, 200);
      drive(400, 400);
      repeat (6) begin
        @(negedge clk);
        if (en_steer !== 1'b0) bad++;
      end
    end
    chk("t3_no_steer", bad, 0);
    drive(600, 200);
    drive(400, 400);
    wait_en(1'b1, 40, n);
    chk("t3_rise_edges", n, 17);

    // 4: brief step-off returns to STEER without re-settle; flags hold without strobes
    drive(790, 10);
    drive(790, 10);
    drive(400, 400);
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (en_steer !== 1'b1) bad++;
    end
    chk("t4_steer_held", bad, 0);
`ifdef STEER_STATUS_EN
    chk("t4_state", int'(state_o), 2);
`endif
    @(negedge clk); ld_vld = 1'b0; lft_ld = '0; rght_ld = '0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (en_steer !== 1'b1) bad++;
    end
    chk("t4_flags_hold", bad, 0);
    @(negedge clk); ld_vld = 1'b1; lft_ld = 12'd400; rght_ld = 12'd400;

    // 5: sustained step-off expires grace and falls to SETTLE
    drive(790, 10);
    wait_en(1'b0, 40, n);
    chk("t5_fall_edges", n, 6);
    chk("t5_rider_off", int'(rider_off), 0);
`ifdef STEER_STATUS_EN
    chk("t5_state", int'(state_o), 1);
`endif

    // 6: light load drops to INIT; mid-band weight does not leave INIT
    drive(400, 400);
    wait_en(1'b1, 60, n);
    chk("t6_resettle_edges", n, 17);
    drive(200, 200);
    wait_en(1'b0, 40, n);
    chk("t6_drop_edges", n, 2);
    chk("t6_rider_off", int'(rider_off), 1);
`ifdef STEER_STATUS_EN
    chk("t6_drop_cnt", int'(drop_cnt), 1);
`endif
    drive(250, 250);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rider_off !== 1'b1) bad++;
    end
    chk("t6_hyst_init", bad, 0);

    // 7: reset while steering
    drive(400, 400);
    wait_en(1'b1, 60, n);
    chk("t7_rise_edges", n, 18);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t7_rst_en_steer", int'(en_steer), 0);
    chk("t7_rst_rider_off", int'(rider_off), 1);
`ifdef STEER_STATUS_EN
    chk("t7_rst_drop_cnt", int'(drop_cnt), 0);
`endif
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
